id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register and operand-steering block between the ID stage and the 32-bit ripple ALU of the 5-stage pipelined CPU. It captures decoded operands and control on each clock, and translates ALUOp/funct/opcode into the 3-bit ALU `Signal` code. It presents the ALU with `dataA`/`dataB` (immediate or register), optionally forwarded from later stages. It also handles hazard-unit stall (hold) and flush (bubble insertion).

## Interface
- Parameters
  - `DW`, default 32: datapath width.
  - `RW`, default 5: register-index width.
- Ports
  - `clk` in 1: rising-edge clock.
  - `rst_n` in 1: reset, **asynchronous and active-low**.
  - `stall` in 1: hold all stage registers.
  - `flush` in 1: load a bubble.
  - `id_valid` in 1: ID holds a real instruction.
  - `id_rs_data`, `id_rt_data` in DW: register-file read data.
  - `id_imm` in 16: instruction immediate.
  - `id_rs`, `id_rt`, `id_rd` in RW: register indices.
  - `id_opcode`, `id_funct` in 6: instruction fields.
  - `id_alu_op` in 2: main-decoder ALUOp.
  - `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: main-decoder controls.
  - `mem_reg_write` in 1, `mem_write_reg` in RW, `mem_alu_result` in DW: EX/MEM forwarding source (used only with forwarding).
  - `wb_reg_write` in 1, `wb_write_reg` in RW, `wb_data` in DW: MEM/WB forwarding source (used only with forwarding).
  - `ex_dataA`, `ex_dataB` out DW: ALU operands.
  - `ex_alu_signal` out 3: ALU `Signal`; bit 2 also drives the bit-0 carry-in.
  - `ex_store_data` out DW: rt value for stores.
  - `ex_write_reg` out RW: destination index.
  - `ex_rs`, `ex_rt` out RW: indices for the hazard unit.
  - `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: controls passed downstream.
  - `ex_valid` out 1: EX slot holds a real instruction.
  - `ex_illegal` out 1: unsupported ALU operation decoded.

## Operation
- ALU codes: AND `000`, OR `001`, ADD `010`, SUB `110`, SLT `111`.
- ALU code decode, done in ID and registered:
  - ALUOp `00` → ADD.
  - ALUOp `01` → SUB.
  - ALUOp `10` → decode funct:
    - `0x20` ADD, `0x22` SUB, `0x24` AND, `0x25` OR, `0x2A` SLT.
    - Any other funct → ADD with `ex_illegal`=1.
  - ALUOp `11` → decode opcode:
    - `0x08` ADD, `0x0C` AND, `0x0D` OR, `0x0A` SLT.
    - Any other opcode → ADD with `ex_illegal`=1.
- Immediate extension: zero-extended for opcodes `0x0C`/`0x0D`; sign-extended for all others.
- Destination: `ex_write_reg` = `reg_dst` ? rd : rt.
- `ex_dataA` = fwd(rs).
- `ex_dataB` = `alu_src` ? imm32 : fwd(rt).
- `ex_store_data` = fwd(rt).
- Flush bubble:
  - All controls, `ex_valid` and `ex_illegal` = 0.
  - Indices and data = 0.
  - Signal = ADD.
- `ex_illegal` is gated by `id_valid`.

## Timing
- Latency is 1 cycle: ID values captured at edge N appear at EX outputs after edge N.
- Forwarding muxes are combinational on registered state; they add no latency.
- Per-edge priority: `rst_n` low > `flush` > `stall` > load.
- Stall: every register holds. Forwarded operands may still change with MEM/WB inputs.
- Flush and stall asserted together → bubble is loaded.
- Reset, asynchronous: all registers take bubble values immediately.
  - Outputs: all 0, except `ex_alu_signal`=`010`.
  - Reset mid-stall discards the held instruction.
- Writes to register 0 are never forwarded.

## Configuration
- Macro `ID_EX_FWD_EN`.
- Defined:
  - fwd(r) = `mem_alu_result` if `mem_reg_write` && `mem_write_reg`==r && r≠0.
  - Else `wb_data` if `wb_reg_write` && `wb_write_reg`==r && r≠0.
  - Else the registered read data. EX/MEM has priority over MEM/WB.
- Undefined:
  - fwd(r) = registered read data.
  - The `mem_*`/`wb_*` ports stay present and are ignored. Hazards are resolved by stalls only.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU code constants.
  - ALUOp encodings.
  - Funct and opcode constants.
  - A bubble-value constant.
- One natural sub-module: `alu_ctrl`, a combinational ALUOp/funct/opcode → {signal, illegal} decoder, reusable by the ALU testbench.
- Forwarding muxes stay inline.

## Test plan
- R-type `and`, funct `0x24`, rs=0x0F0F, rt=0x00FF → next cycle signal `000`, dataA=0x0F0F, dataB=0x00FF, write_reg=rd.
- `ori` opcode `0x0D`, imm=0x8001 → signal `001`, dataB=0x00008001. Same imm on `addi` → 0xFFFF8001.
- Stall held 3 cycles with ID inputs changing → outputs frozen. Flush+stall together → `ex_valid`=0, signal `010`, all controls 0.
- With `ID_EX_FWD_EN`, EX rs=5:
  - mem_write_reg=5 with 0x11 and wb_write_reg=5 with 0x22 → dataA=0x11.
  - Drop `mem_reg_write` → dataA=0x22.
  - rs=0 with both writing reg 0 → dataA = registered data.
- Funct `0x27` with ALUOp `10` → signal `010`, `ex_illegal`=1. Same inputs with `id_valid`=0 → `ex_illegal`=0.
- `rst_n` dropped between clock edges during a valid instruction → outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU codes, decoder encodings and ID/EX bubble value
package cpu_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OPC   = 2'b11;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] signal;
    } ex_ctrl_t;
    localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, illegal: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
                                         mem_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b0, signal: ALU_ADD};
    function automatic logic zero_ext(input logic [5:0] opcode);
        return opcode == OP_ANDI || opcode == OP_ORI;
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, forwarding sources and EX-side outputs of the ID/EX stage
interface id_ex_stage_if #(parameter int DW = 32, parameter int RW = 5);
    logic          stall, flush, id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data;
    logic [15:0]   id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [5:0]    id_opcode, id_funct;
    logic [1:0]    id_alu_op;
    logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          mem_reg_write, wb_reg_write;
    logic [RW-1:0] mem_write_reg, wb_write_reg;
    logic [DW-1:0] mem_alu_result, wb_data;
    logic [DW-1:0] ex_dataA, ex_dataB, ex_store_data;
    logic [2:0]    ex_alu_signal;
    logic [RW-1:0] ex_write_reg, ex_rs, ex_rt;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, ex_illegal;
    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_opcode, id_funct, id_alu_op, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_data,
        input  ex_dataA, ex_dataB, ex_store_data, ex_alu_signal, ex_write_reg, ex_rs, ex_rt,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, ex_illegal
    );
    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_opcode, id_funct, id_alu_op, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_data,
        output ex_dataA, ex_dataB, ex_store_data, ex_alu_signal, ex_write_reg, ex_rs, ex_rt,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, ex_illegal
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: combinational ALUOp/funct/opcode to ALU signal decoder with illegal flag
module alu_ctrl
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [2:0] signal,
    output logic       illegal
);
    // unsupported funct/opcode falls back to ADD and raises illegal
    always_comb begin
        signal  = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: signal = ALU_ADD;
            ALUOP_SUB: signal = ALU_SUB;
            ALUOP_FUNCT:
                case (funct)
                    FN_ADD:  signal = ALU_ADD;
                    FN_SUB:  signal = ALU_SUB;
                    FN_AND:  signal = ALU_AND;
                    FN_OR:   signal = ALU_OR;
                    FN_SLT:  signal = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            default:
                case (opcode)
                    OP_ADDI: signal = ALU_ADD;
                    OP_ANDI: signal = ALU_AND;
                    OP_ORI:  signal = ALU_OR;
                    OP_SLTI: signal = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU operand steering; ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic         clk,
    input logic         rst_n,
    id_ex_stage_if.slave bus
);
    logic [2:0]    id_signal;
    logic          id_illegal;
    logic [DW-1:0] id_imm32;
    ex_ctrl_t      id_ctrl, ctrl_q;
    logic [DW-1:0] rs_val_q, rt_val_q, imm_q, rs_fwd, rt_fwd;
    logic [RW-1:0] rs_q, rt_q, wr_q;

    alu_ctrl u_alu_ctrl (
        .alu_op (bus.id_alu_op),
        .funct  (bus.id_funct),
        .opcode (bus.id_opcode),
        .signal (id_signal),
        .illegal(id_illegal)
    );

    assign id_imm32 = {{(DW-16){bus.id_imm[15] & ~zero_ext(bus.id_opcode)}}, bus.id_imm};
    assign id_ctrl  = '{valid: bus.id_valid, illegal: bus.id_valid & id_illegal,
                        reg_write: bus.id_reg_write, mem_read: bus.id_mem_read,
                        mem_write: bus.id_mem_write, mem_to_reg: bus.id_mem_to_reg,
                        alu_src: bus.id_alu_src, signal: id_signal};

    // stage register: reset and flush load a bubble, stall holds, otherwise capture ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= BUBBLE_CTRL;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            wr_q     <= '0;
        end else if (bus.flush) begin
            ctrl_q   <= BUBBLE_CTRL;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            wr_q     <= '0;
        end else if (!bus.stall) begin
            ctrl_q   <= id_ctrl;
            rs_val_q <= bus.id_rs_data;
            rt_val_q <= bus.id_rt_data;
            imm_q    <= id_imm32;
            rs_q     <= bus.id_rs;
            rt_q     <= bus.id_rt;
            wr_q     <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        end
    end

`ifdef ID_EX_FWD_EN
    // EX/MEM beats MEM/WB; register 0 is never forwarded
    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] r, input logic [DW-1:0] d);
        return (bus.mem_reg_write && bus.mem_write_reg == r && r != '0) ? bus.mem_alu_result :
               (bus.wb_reg_write && bus.wb_write_reg == r && r != '0) ? bus.wb_data : d;
    endfunction
    assign rs_fwd = fwd(rs_q, rs_val_q);
    assign rt_fwd = fwd(rt_q, rt_val_q);
`else
    assign rs_fwd = rs_val_q;
    assign rt_fwd = rt_val_q;
`endif

    assign bus.ex_dataA      = rs_fwd;
    assign bus.ex_dataB      = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign bus.ex_store_data = rt_fwd;
    assign bus.ex_alu_signal = ctrl_q.signal;
    assign bus.ex_write_reg  = wr_q;
    assign bus.ex_rs         = rs_q;
    assign bus.ex_rt         = rt_q;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_valid      = ctrl_q.valid;
    assign bus.ex_illegal    = ctrl_q.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized self-checking bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();
    id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic        m_valid, m_ill, m_rw, m_mr, m_mw, m_m2r, m_src;
    logic [2:0]  m_sig;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_rs, m_rt, m_wr;
    logic [119:0] snap;

    task automatic m_bubble();
        {m_valid, m_ill, m_rw, m_mr, m_mw, m_m2r, m_src} = '0;
        m_sig = 3'b010;
        m_a = 0; m_b = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_wr = 0;
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn, input logic [5:0] opc,
                                       output logic [2:0] sig, output logic ill);
        sig = 3'b010;
        ill = 1'b0;
        if (op == 2'd1) sig = 3'b110;
        else if (op == 2'd2) begin
            if (fn == 6'h22) sig = 3'b110;
            else if (fn == 6'h24) sig = 3'b000;
            else if (fn == 6'h25) sig = 3'b001;
            else if (fn == 6'h2A) sig = 3'b111;
            else if (fn != 6'h20) ill = 1'b1;
        end else if (op == 2'd3) begin
            if (opc == 6'h0C) sig = 3'b000;
            else if (opc == 6'h0D) sig = 3'b001;
            else if (opc == 6'h0A) sig = 3'b111;
            else if (opc != 6'h08) ill = 1'b1;
        end
    endfunction

    task automatic m_edge();
        logic [2:0] s;
        logic il;
        if (bus.flush) m_bubble();
        else if (!bus.stall) begin
            ref_decode(bus.id_alu_op, bus.id_funct, bus.id_opcode, s, il);
            m_sig = s;
            m_ill = il && bus.id_valid;
            m_valid = bus.id_valid;
            m_rw = bus.id_reg_write; m_mr = bus.id_mem_read; m_mw = bus.id_mem_write;
            m_m2r = bus.id_mem_to_reg; m_src = bus.id_alu_src;
            m_a = bus.id_rs_data; m_b = bus.id_rt_data;
            m_imm = (bus.id_opcode == 6'h0C || bus.id_opcode == 6'h0D) ? {16'h0, bus.id_imm}
                                                                       : 32'($signed(bus.id_imm));
            m_rs = bus.id_rs; m_rt = bus.id_rt;
            m_wr = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FWD_EN
        if (r != 0 && bus.mem_reg_write && bus.mem_write_reg == r) return bus.mem_alu_result;
        if (r != 0 && bus.wb_reg_write && bus.wb_write_reg == r) return bus.wb_data;
`endif
        return d;
    endfunction

    function automatic logic [119:0] exp_vec();
        return {ref_fwd(m_rs, m_a), m_src ? m_imm : ref_fwd(m_rt, m_b), ref_fwd(m_rt, m_b), m_sig,
                m_wr, m_rs, m_rt, m_rw, m_mr, m_mw, m_m2r, m_valid, m_ill};
    endfunction

    function automatic logic [119:0] obs_vec();
        return {bus.ex_dataA, bus.ex_dataB, bus.ex_store_data, bus.ex_alu_signal, bus.ex_write_reg,
                bus.ex_rs, bus.ex_rt, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                bus.ex_mem_to_reg, bus.ex_valid, bus.ex_illegal};
    endfunction

    task automatic step();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_id();
        int k;
        bus.id_valid = $urandom_range(0, 3) != 0;
        bus.id_alu_op = 2'($urandom);
        k = $urandom_range(0, 5);
        bus.id_funct = k == 0 ? 6'h20 : k == 1 ? 6'h22 : k == 2 ? 6'h24 : k == 3 ? 6'h25 : k == 4 ? 6'h2A : 6'($urandom);
        k = $urandom_range(0, 4);
        bus.id_opcode = k == 0 ? 6'h08 : k == 1 ? 6'h0A : k == 2 ? 6'h0C : k == 3 ? 6'h0D : 6'($urandom);
        bus.id_imm = 16'($urandom);
        bus.id_rs = 5'($urandom_range(0, 7));
        bus.id_rt = 5'($urandom_range(0, 7));
        bus.id_rd = 5'($urandom);
        bus.id_rs_data = $urandom;
        bus.id_rt_data = $urandom;
        {bus.id_alu_src, bus.id_reg_dst, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg} = 6'($urandom);
    endtask

    task automatic rand_fwd();
        bus.mem_reg_write = 1'($urandom);
        bus.mem_write_reg = 5'($urandom_range(0, 7));
        bus.mem_alu_result = $urandom;
        bus.wb_reg_write = 1'($urandom);
        bus.wb_write_reg = 5'($urandom_range(0, 7));
        bus.wb_data = $urandom;
    endtask

    task automatic clear_fwd();
        bus.mem_reg_write = 0; bus.mem_write_reg = 0; bus.mem_alu_result = 0;
        bus.wb_reg_write = 0; bus.wb_write_reg = 0; bus.wb_data = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall = 0; bus.flush = 0;
        rand_id();
        clear_fwd();
        m_bubble();
        #12;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL reset_vec got=%h exp=%h", obs_vec(), exp_vec()); failures++;
        end
        checks++;
        if (bus.ex_alu_signal !== 3'b010 || bus.ex_valid !== 1'b0) begin
            $display("FAIL reset_sig got=%b/%b exp=010/0", bus.ex_alu_signal, bus.ex_valid); failures++;
        end
        checks++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_and();
        rand_id();
        bus.id_valid = 1; bus.id_alu_op = 2'b10; bus.id_funct = 6'h24;
        bus.id_rs = 4; bus.id_rt = 3; bus.id_rd = 9;
        bus.id_rs_data = 32'h0F0F; bus.id_rt_data = 32'h00FF;
        bus.id_alu_src = 0; bus.id_reg_dst = 1;
        step();
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL and_vec got=%h exp=%h", obs_vec(), exp_vec()); failures++;
        end
        checks++;
        if ({bus.ex_alu_signal, bus.ex_dataA, bus.ex_dataB, bus.ex_write_reg} !== {3'b000, 32'h0F0F, 32'h00FF, 5'd9}) begin
            $display("FAIL and_fields got=%b %h %h %0d exp=000 0f0f 00ff 9", bus.ex_alu_signal, bus.ex_dataA, bus.ex_dataB, bus.ex_write_reg);
            failures++;
        end
        checks++;
    endtask

    task automatic test_imm();
        rand_id();
        bus.id_valid = 1; bus.id_alu_op = 2'b11; bus.id_opcode = 6'h0D; bus.id_imm = 16'h8001; bus.id_alu_src = 1;
        step();
        if (bus.ex_alu_signal !== 3'b001 || bus.ex_dataB !== 32'h0000_8001) begin
            $display("FAIL ori got=%b %h exp=001 00008001", bus.ex_alu_signal, bus.ex_dataB); failures++;
        end
        checks++;
        bus.id_opcode = 6'h08;
        step();
        if (bus.ex_alu_signal !== 3'b010 || bus.ex_dataB !== 32'hFFFF_8001) begin
            $display("FAIL addi got=%b %h exp=010 ffff8001", bus.ex_alu_signal, bus.ex_dataB); failures++;
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL addi_vec got=%h exp=%h", obs_vec(), exp_vec()); failures++;
        end
        checks++;
    endtask

    task automatic test_stall();
        rand_id();
        bus.id_valid = 1;
        step();
        snap = obs_vec();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step();
            if (obs_vec() !== snap || obs_vec() !== exp_vec()) begin
                $display("FAIL stall_hold%0d got=%h exp=%h", i, obs_vec(), snap); failures++;
            end
            checks++;
        end
        bus.flush = 1;
        step();
        if ({bus.ex_valid, bus.ex_alu_signal, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg} !== 9'b0_010_0000) begin
            $display("FAIL flush_stall got=%b%b%b%b%b%b exp=0_010_0000", bus.ex_valid, bus.ex_alu_signal, bus.ex_reg_write,
                     bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg);
            failures++;
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL flush_vec got=%h exp=%h", obs_vec(), exp_vec()); failures++;
        end
        checks++;
        bus.flush = 0; bus.stall = 0;
    endtask

    task automatic test_illegal();
        rand_id();
        bus.id_valid = 1; bus.id_alu_op = 2'b10; bus.id_funct = 6'h27;
        step();
        if (bus.ex_alu_signal !== 3'b010 || bus.ex_illegal !== 1'b1) begin
            $display("FAIL illegal got=%b %b exp=010 1", bus.ex_alu_signal, bus.ex_illegal); failures++;
        end
        checks++;
        bus.id_valid = 0;
        step();
        if (bus.ex_illegal !== 1'b0 || obs_vec() !== exp_vec()) begin
            $display("FAIL illegal_gated got=%b exp=0 vec=%h", bus.ex_illegal, obs_vec()); failures++;
        end
        checks++;
    endtask

    task automatic test_fwd();
        logic [31:0] e;
        clear_fwd();
        rand_id();
        bus.id_valid = 1; bus.id_rs = 5; bus.id_rs_data = 32'hAAAA;
        step();
        bus.stall = 1;
        bus.mem_reg_write = 1; bus.mem_write_reg = 5; bus.mem_alu_result = 32'h11;
        bus.wb_reg_write = 1; bus.wb_write_reg = 5; bus.wb_data = 32'h22;
        #1;
`ifdef ID_EX_FWD_EN
        e = 32'h11;
`else
        e = 32'hAAAA;
`endif
        if (bus.ex_dataA !== e) begin
            $display("FAIL fwd_mem got=%h exp=%h", bus.ex_dataA, e); failures++;
        end
        checks++;
        bus.mem_reg_write = 0;
        #1;
`ifdef ID_EX_FWD_EN
        e = 32'h22;
`else
        e = 32'hAAAA;
`endif
        if (bus.ex_dataA !== e || obs_vec() !== exp_vec()) begin
            $display("FAIL fwd_wb got=%h exp=%h", bus.ex_dataA, e); failures++;
        end
        checks++;
        bus.stall = 0;
        bus.id_rs = 0; bus.id_rs_data = 32'h3333;
        bus.mem_reg_write = 1; bus.mem_write_reg = 0; bus.wb_write_reg = 0;
        step();
        if (bus.ex_dataA !== 32'h3333) begin
            $display("FAIL fwd_r0 got=%h exp=00003333", bus.ex_dataA); failures++;
        end
        checks++;
        clear_fwd();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_id();
            rand_fwd();
            bus.stall = $urandom_range(0, 3) == 0;
            bus.flush = $urandom_range(0, 7) == 0;
            step();
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random%0d got=%h exp=%h", i, obs_vec(), exp_vec()); failures++;
            end
            checks++;
        end
        bus.stall = 0; bus.flush = 0;
        clear_fwd();
    endtask

    task automatic test_async_reset();
        rand_id();
        bus.id_valid = 1; bus.id_alu_op = 2'b01;
        step();
        bus.stall = 1;
        #3;
        rst_n = 1'b0;
        #1;
        m_bubble();
        if (obs_vec() !== exp_vec() || bus.ex_valid !== 1'b0) begin
            $display("FAIL async_reset got=%h exp=%h", obs_vec(), exp_vec()); failures++;
        end
        checks++;
        #1;
        rst_n = 1'b1;
        bus.stall = 0;
        rand_id();
        step();
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL post_reset got=%h exp=%h", obs_vec(), exp_vec()); failures++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_and();
        test_imm();
        test_stall();
        test_illegal();
        test_fwd();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
